alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one parameter: PRIO_FIXED, default 0, 0 = round-robin grant, 1 = port 0 fixed priority.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 reqN_valid  input  1  (N = 0,1) requester N presents an operation.
REQ-005 reqN_ready  output  1  block accepts requester N's operation this cycle.
REQ-006 reqN_a, reqN_b  input  32 each  operands A, B of requester N.
REQ-007 reqN_op  input  3  ALU control code of requester N.
REQ-008 rspN_valid  output  1  result for requester N is available.
REQ-009 rspN_ready  input  1  requester N consumes the result.
REQ-010 rspN_result  output  32  ALU result returned to requester N.
REQ-011 rspN_zero  output  1  zero flag returned to requester N.
REQ-012 srca, srcb  output  32 each  operands driven to the shared combinational ALU.
REQ-013 alucontrol  output  3  control code driven to the shared ALU.
REQ-014 aluout  input  32  shared ALU result, same-cycle combinational.
REQ-015 zero  input  1  shared ALU zero flag.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The block SHALL implement the states IDLE, EXEC and RESP.
REQ-018 In IDLE, exactly one reqN_ready SHALL be high, namely the one for the granted port, and only if that port's reqN_valid is high.
REQ-019 Grant: if only one port is valid, it wins; if both are valid, round-robin picks the port not granted last; PRIO_FIXED=1 always picks port 0.
REQ-020 The round-robin last-grant pointer SHALL reset to port 1 and SHALL update only on an accepted transfer.
REQ-021 A transfer (valid & ready) SHALL latch a, b, op and the owner id into internal registers, and the state SHALL move to EXEC.
REQ-022 srca, srcb and alucontrol SHALL always be driven from the latched registers, with no combinational path from the reqN_* inputs.
REQ-023 In EXEC, which lasts exactly one cycle, aluout and zero SHALL be captured into the result registers, and the state SHALL move to RESP.
REQ-024 In RESP, only the owner's rspN_valid SHALL be high, and rspN_result and rspN_zero SHALL stay stable until rspN_ready is high.
REQ-025 On RESP with rspN_ready high, the state SHALL return to IDLE on the next edge.
REQ-026 rspN_valid of the non-owner port, and all rspN_valid outside RESP, SHALL be low.
REQ-027 Latency SHALL be as follows: transfer on edge t, rspN_valid high during cycle t+2; with immediate rsp_ready, one operation completes every 3 cycles.
REQ-028 Codes SHALL be forwarded unmodified: 000 AND, 001 OR, 010 ADD, 100 A AND ~B, 101 A OR ~B, 110 SUB, 111 SLT (result 0 or 1), 011 unused with result 0.
REQ-029 Deasserting reqN_valid without a transfer is legal and SHALL have no effect on the state.
REQ-030 No request SHALL be accepted in EXEC or RESP, and reqN_ready SHALL be low in those states.
REQ-031 rspN_result and rspN_zero of the non-owner port SHALL be driven to zero.

Reset
REQ-032 Reset SHALL set the state to IDLE, the last-grant pointer to 1, and all operand, op, owner and result registers to 0.
REQ-033 After reset, all outputs SHALL read 0 (busy, rspN_valid, srca, srcb, alucontrol, results), except reqN_ready, which follows REQ-018.
REQ-034 Reset in EXEC or RESP SHALL discard the operation, and no rspN_valid SHALL appear for it.
REQ-035 Reset SHALL take priority over every simultaneous transfer or response handshake.

Verification
REQ-036 Reset held 2 cycles, no requests -> busy=0, rsp0/1_valid=0, srca=srcb=0, alucontrol=000.
REQ-037 Port 0: a=5, b=7, op=010, single request -> req0_ready=1 at accept; rsp0_valid at t+2 with result=12, zero=0.
REQ-038 Both ports valid from first cycle after reset: port 0 first (a=9, b=9, op=110 -> result=0, zero=1), then port 1 (a=3, b=4, op=111 -> result=1, zero=0).
REQ-039 rsp0_ready held low 3 cycles in RESP while req1_valid is high -> rsp0_valid and result stay stable, req1_ready=0, busy=1; port 1 accepted on the first IDLE cycle after rsp0_ready.
REQ-040 Reset asserted in EXEC -> no rspN_valid for that operation; next request (op=001, a=0xF0, b=0x0F) returns 0xFF.
REQ-041 PRIO_FIXED=1 with both ports continuously valid for 4 operations -> all 4 grants go to port 0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one external combinational ALU between two requesters.
// A request is accepted in IDLE, its operands are held in registers that drive
// the ALU during EXEC, and the captured result is returned to the owning port
// in RESP until that port takes it.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   reqN_valid/ready/a/b/op  (N=0,1)   request handshake, operands, ALU code
//   rspN_valid/ready/result/zero       response handshake, result, zero flag
//   srca, srcb, alucontrol             operands and code to the shared ALU
//   aluout, zero                       shared ALU result and zero flag
//   busy                               high whenever the block is not IDLE
module alu_arbiter #(
  parameter int PRIO_FIXED = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,
  output logic [31:0] srca,
  output logic [31:0] srcb,
  output logic [2:0]  alucontrol,
  input  logic [31:0] aluout,
  input  logic        zero,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_next_s;
  logic        last_r;      // port granted by the most recent accepted transfer
  logic        owner_r;     // port that owns the operation in flight
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [2:0]  op_r;
  logic [31:0] result_r;
  logic        zero_r;
  logic        grant_s;     // port that would be granted this cycle
  logic        xfer_s;      // a request is accepted this cycle
  logic        rsp_hs_s;    // owner consumes the response this cycle

  // Grant selection: lone requester wins; on contention fixed or round-robin.
  always_comb begin
    grant_s = 1'b0;
    if (PRIO_FIXED != 0) begin
      grant_s = req0_valid ? 1'b0 : 1'b1;
    end else if (req0_valid && req1_valid) begin
      grant_s = ~last_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Handshake decode for request acceptance and response consumption.
  always_comb begin
    req0_ready = (state_r == IDLE) && !grant_s && req0_valid;
    req1_ready = (state_r == IDLE) &&  grant_s && req1_valid;
    xfer_s     = req0_ready || req1_ready;
    rsp_hs_s   = (state_r == RESP) && (owner_r ? rsp1_ready : rsp0_ready);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    state_next_s = xfer_s ? EXEC : IDLE;
      EXEC:    state_next_s = RESP;
      RESP:    state_next_s = rsp_hs_s ? IDLE : RESP;
      default: state_next_s = IDLE;
    endcase
  end

  // Operand latch on transfer, result capture in EXEC, grant pointer update.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_r   <= 1'b1;
      owner_r  <= 1'b0;
      a_r      <= 32'd0;
      b_r      <= 32'd0;
      op_r     <= 3'd0;
      result_r <= 32'd0;
      zero_r   <= 1'b0;
    end else begin
      if (xfer_s) begin
        last_r  <= grant_s;
        owner_r <= grant_s;
        a_r     <= grant_s ? req1_a  : req0_a;
        b_r     <= grant_s ? req1_b  : req0_b;
        op_r    <= grant_s ? req1_op : req0_op;
      end
      if (state_r == EXEC) begin
        result_r <= aluout;
        zero_r   <= zero;
      end
    end
  end

  // Output decode; the ALU is fed only from the latched operand registers.
  always_comb begin
    srca        = a_r;
    srcb        = b_r;
    alucontrol  = op_r;
    busy        = (state_r != IDLE);
    rsp0_valid  = (state_r == RESP) && !owner_r;
    rsp1_valid  = (state_r == RESP) &&  owner_r;
    rsp0_result = owner_r ? 32'd0 : result_r;
    rsp0_zero   = owner_r ? 1'b0  : zero_r;
    rsp1_result = owner_r ? result_r : 32'd0;
    rsp1_zero   = owner_r ? zero_r   : 1'b0;
  end

endmodule
